// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle of every signal exchanged between the pipeline control sequencer
// and its surroundings (instruction decoder and datapath).
//
//   master : decoder/datapath side. Drives the decode-stage control word,
//            register addresses and ALU flags; receives the E/M/W controls,
//            forwarding selects, stall/flush controls and the NZCV register.
//   slave  : pipe_hazard_ctrl side (the mirror image of master).
//
// Parameters: RA_W = register-address width, ALUC_W = ALUControl width.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int RA_W   = 4,
    parameter int ALUC_W = 3
);
    // Decode-stage control word
    logic              PCSD;
    logic              RegWD;
    logic              MemtoRegD;
    logic              MemWD;
    logic              BranchD;
    logic              ALUSrcD;
    logic [ALUC_W-1:0] ALUControlD;
    logic [1:0]        FlagWD;
    logic [3:0]        CondD;
    logic [RA_W-1:0]   RA1D;
    logic [RA_W-1:0]   RA2D;
    logic [RA_W-1:0]   WA3D;

    // Execute-stage ALU flags {N,Z,C,V}
    logic [3:0]        ALUFlagsE;

    // Controls carried down the pipe
    logic [ALUC_W-1:0] ALUControlE;
    logic              ALUSrcE;
    logic              BranchTakenE;
    logic              MemWriteM;
    logic              RegWriteW;
    logic              MemtoRegW;
    logic              PCSrcW;
    logic [RA_W-1:0]   WA3W;

    // Hazard unit outputs
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic [3:0]        FlagsQ;

    modport master (
        output PCSD, RegWD, MemtoRegD, MemWD, BranchD, ALUSrcD, ALUControlD,
               FlagWD, CondD, RA1D, RA2D, WA3D, ALUFlagsE,
        input  ALUControlE, ALUSrcE, BranchTakenE, MemWriteM, RegWriteW,
               MemtoRegW, PCSrcW, WA3W, ForwardAE, ForwardBE, StallF, StallD,
               FlushD, FlushE, FlagsQ
    );

    modport slave (
        input  PCSD, RegWD, MemtoRegD, MemWD, BranchD, ALUSrcD, ALUControlD,
               FlagWD, CondD, RA1D, RA2D, WA3D, ALUFlagsE,
        output ALUControlE, ALUSrcE, BranchTakenE, MemWriteM, RegWriteW,
               MemtoRegW, PCSrcW, WA3W, ForwardAE, ForwardBE, StallF, StallD,
               FlushD, FlushE, FlagsQ
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline control sequencer for the 5-stage (F/D/E/M/W) RSA CPU. Carries the
// decoder's control word through E/M/W, evaluates the condition field against
// the held NZCV register, and produces forwarding selects plus the stall and
// flush controls for the datapath pipeline registers.
//
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (decode control word, ALU flags in;
//           E/M/W controls, forwarding, stall/flush, FlagsQ out)
//
// Build option:
//   PIPE_FWD_EN defined   : M/W -> E operand forwarding, stall only on
//                           load-use.
//   PIPE_FWD_EN undefined : no forwarding (selects tied to 00); any RAW
//                           dependency on an instruction in E or M stalls D.
//                           The regfile writes on the falling edge, so W
//                           never needs a check.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int RA_W   = 4,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    // D->E control register
    logic              pcsE_q, regWE_q, memtoRegE_q, memWE_q, branchE_q, aluSrcE_q;
    logic [ALUC_W-1:0] aluCtlE_q;
    logic [1:0]        flagWE_q;
    logic [3:0]        condE_q;
    logic [RA_W-1:0]   wa3E_q;

    // E->M and M->W control registers (write enables already cond-gated)
    logic              regWriteM_q, memWriteM_q, pcSrcM_q, memtoRegM_q;
    logic [RA_W-1:0]   wa3M_q;
    logic              regWriteW_q, memtoRegW_q, pcSrcW_q;
    logic [RA_W-1:0]   wa3W_q;

    logic [3:0]        flags_q, flags_d;
    logic              flagN, flagZ, flagC, flagV;
    logic              condExE, hazardStall, pcWrPending, branchTakenE, flushE;
    logic [1:0]        forwardA, forwardB;

    assign {flagN, flagZ, flagC, flagV} = flags_q;

    always_comb begin
        condExE = 1'b0;
        case (condE_q)
            4'b0000: condExE = flagZ;
            4'b0001: condExE = !flagZ;
            4'b0010: condExE = flagC;
            4'b0011: condExE = !flagC;
            4'b0100: condExE = flagN;
            4'b0101: condExE = !flagN;
            4'b0110: condExE = flagV;
            4'b0111: condExE = !flagV;
            4'b1000: condExE = flagC & !flagZ;
            4'b1001: condExE = !flagC | flagZ;
            4'b1010: condExE = (flagN == flagV);
            4'b1011: condExE = (flagN != flagV);
            4'b1100: condExE = !flagZ & (flagN == flagV);
            4'b1101: condExE = flagZ | (flagN != flagV);
            4'b1110: condExE = 1'b1;
            default: condExE = 1'b0;
        endcase
    end

    // NZ and CV are written independently so a flag-setting op can preserve
    // the half it does not own.
    always_comb begin
        flags_d = flags_q;
        if (flagWE_q[1] && condExE) flags_d[3:2] = bus.ALUFlagsE[3:2];
        if (flagWE_q[0] && condExE) flags_d[1:0] = bus.ALUFlagsE[1:0];
    end

`ifdef PIPE_FWD_EN
    logic [RA_W-1:0] ra1E_q, ra2E_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra1E_q <= '0;
            ra2E_q <= '0;
        end else if (flushE) begin
            ra1E_q <= '0;
            ra2E_q <= '0;
        end else begin
            ra1E_q <= bus.RA1D;
            ra2E_q <= bus.RA2D;
        end
    end

    // M is the younger producer, so it takes priority over W.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (regWriteM_q && (ra1E_q == wa3M_q))      forwardA = 2'b10;
        else if (regWriteW_q && (ra1E_q == wa3W_q)) forwardA = 2'b01;
        if (regWriteM_q && (ra2E_q == wa3M_q))      forwardB = 2'b10;
        else if (regWriteW_q && (ra2E_q == wa3W_q)) forwardB = 2'b01;
    end

    // Only a load in E cannot be forwarded in time.
    assign hazardStall = memtoRegE_q & regWE_q &
                         ((bus.RA1D == wa3E_q) | (bus.RA2D == wa3E_q));
`else
    assign forwardA = 2'b00;
    assign forwardB = 2'b00;

    // The E term uses the ungated write enable because the condition of the
    // producer is not known early enough to release the consumer.
    assign hazardStall = (regWE_q & ((bus.RA1D == wa3E_q) | (bus.RA2D == wa3E_q))) |
                         (regWriteM_q & ((bus.RA1D == wa3M_q) | (bus.RA2D == wa3M_q)));
`endif

    // The raw PCSD input is masked by rst_n so every output reads zero while
    // reset is held, even if the decoder still presents a PC write.
    assign pcWrPending  = (bus.PCSD & rst_n) | pcsE_q | pcSrcM_q;
    assign branchTakenE = branchE_q & condExE;
    assign flushE       = hazardStall | branchTakenE;

    // D->E takes a bubble on flush; E->M and M->W always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcsE_q      <= 1'b0;
            regWE_q     <= 1'b0;
            memtoRegE_q <= 1'b0;
            memWE_q     <= 1'b0;
            branchE_q   <= 1'b0;
            aluSrcE_q   <= 1'b0;
            aluCtlE_q   <= '0;
            flagWE_q    <= '0;
            condE_q     <= '0;
            wa3E_q      <= '0;
            regWriteM_q <= 1'b0;
            memWriteM_q <= 1'b0;
            pcSrcM_q    <= 1'b0;
            memtoRegM_q <= 1'b0;
            wa3M_q      <= '0;
            regWriteW_q <= 1'b0;
            memtoRegW_q <= 1'b0;
            pcSrcW_q    <= 1'b0;
            wa3W_q      <= '0;
            flags_q     <= '0;
        end else begin
            if (flushE) begin
                pcsE_q      <= 1'b0;
                regWE_q     <= 1'b0;
                memtoRegE_q <= 1'b0;
                memWE_q     <= 1'b0;
                branchE_q   <= 1'b0;
                aluSrcE_q   <= 1'b0;
                aluCtlE_q   <= '0;
                flagWE_q    <= '0;
                condE_q     <= '0;
                wa3E_q      <= '0;
            end else begin
                pcsE_q      <= bus.PCSD;
                regWE_q     <= bus.RegWD;
                memtoRegE_q <= bus.MemtoRegD;
                memWE_q     <= bus.MemWD;
                branchE_q   <= bus.BranchD;
                aluSrcE_q   <= bus.ALUSrcD;
                aluCtlE_q   <= bus.ALUControlD;
                flagWE_q    <= bus.FlagWD;
                condE_q     <= bus.CondD;
                wa3E_q      <= bus.WA3D;
            end
            regWriteM_q <= regWE_q & condExE;
            memWriteM_q <= memWE_q & condExE;
            pcSrcM_q    <= pcsE_q & condExE;
            memtoRegM_q <= memtoRegE_q;
            wa3M_q      <= wa3E_q;
            regWriteW_q <= regWriteM_q;
            memtoRegW_q <= memtoRegM_q;
            pcSrcW_q    <= pcSrcM_q;
            wa3W_q      <= wa3M_q;
            flags_q     <= flags_d;
        end
    end

    // Stall and flush on D together: the datapath lets the flush dominate.
    assign bus.ALUControlE  = aluCtlE_q;
    assign bus.ALUSrcE      = aluSrcE_q;
    assign bus.BranchTakenE = branchTakenE;
    assign bus.MemWriteM    = memWriteM_q;
    assign bus.RegWriteW    = regWriteW_q;
    assign bus.MemtoRegW    = memtoRegW_q;
    assign bus.PCSrcW       = pcSrcW_q;
    assign bus.WA3W         = wa3W_q;
    assign bus.ForwardAE    = forwardA;
    assign bus.ForwardBE    = forwardB;
    assign bus.StallD       = hazardStall;
    assign bus.StallF       = hazardStall | pcWrPending;
    assign bus.FlushE       = flushE;
    assign bus.FlushD       = pcWrPending | pcSrcW_q | branchTakenE;
    assign bus.FlagsQ       = flags_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. A behavioural model tracks the
// three in-flight control words (E, M, W) together with whether each one's
// condition held, and derives every output from those words. A compare
// process checks all outputs against the model on every falling edge;
// directed instruction sequences additionally pin hand-computed values.
// Honours PIPE_FWD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    localparam int RA_W   = 4;
    localparam int ALUC_W = 3;
    localparam logic [3:0] AL = 4'b1110;

`ifdef PIPE_FWD_EN
    localparam int         ADD_SUB_STALLS = 0;
    localparam logic [1:0] ADD_SUB_FWD    = 2'b10;
    localparam int         LDR_STALLS     = 1;
    localparam logic [1:0] LDR_FWD        = 2'b01;
`else
    localparam int         ADD_SUB_STALLS = 2;
    localparam logic [1:0] ADD_SUB_FWD    = 2'b00;
    localparam int         LDR_STALLS     = 2;
    localparam logic [1:0] LDR_FWD        = 2'b00;
`endif

    typedef struct packed {
        logic       pcs, regW, memtoReg, memW, branch, aluSrc;
        logic [2:0] aluCtl;
        logic [1:0] flagW;
        logic [3:0] cond, ra1, ra2, wa3;
    } word_t;

    typedef struct packed {
        logic [2:0] aluCtlE;
        logic       aluSrcE, branchTakenE, memWriteM;
        logic       regWriteW, memtoRegW, pcSrcW;
        logic [3:0] wa3W;
        logic [1:0] fwdA, fwdB;
        logic       stallF, stallD, flushD, flushE;
        logic [3:0] flags;
    } outs_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    errCount = 0;
    int    checkCount = 0;
    logic  checkEnable = 1'b0;

    word_t      dWord;
    logic [3:0] aluF;
    word_t      stage [3];
    logic       execd [3];
    logic [3:0] mFlags;

    pipe_hazard_ctrl_if #(.RA_W(RA_W), .ALUC_W(ALUC_W)) bus ();

    pipe_hazard_ctrl #(.RA_W(RA_W), .ALUC_W(ALUC_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Condition table written straight from the ARM cond-field meanings.
    function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic word_t mkWord(input logic pcs, regW, memtoReg, memW, branch,
                                     input logic [1:0] flagW,
                                     input logic [3:0] cond, ra1, ra2, wa3);
        word_t w;
        w = '0;
        w.pcs = pcs; w.regW = regW; w.memtoReg = memtoReg; w.memW = memW;
        w.branch = branch; w.aluSrc = memtoReg | memW; w.aluCtl = 3'b010;
        w.flagW = flagW; w.cond = cond; w.ra1 = ra1; w.ra2 = ra2; w.wa3 = wa3;
        return w;
    endfunction

    function automatic word_t randWord();
        word_t w;
        w.pcs      = ($urandom_range(0, 15) == 0);
        w.regW     = 1'($urandom);
        w.memtoReg = 1'($urandom);
        w.memW     = 1'($urandom);
        w.branch   = ($urandom_range(0, 3) == 0);
        w.aluSrc   = 1'($urandom);
        w.aluCtl   = 3'($urandom);
        w.flagW    = 2'($urandom);
        w.cond     = $urandom_range(0, 1) ? AL : 4'($urandom);
        w.ra1      = 4'($urandom_range(0, 3));
        w.ra2      = 4'($urandom_range(0, 3));
        w.wa3      = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        return w;
    endfunction

    // Outputs follow from what sits in E, M and W plus the word in D.
    function automatic outs_t modelOutputs();
        outs_t o;
        word_t e, m, w;
        logic  ex, regWM, pcsM, regWW, pcsW, hz, pend;
        e = stage[0]; m = stage[1]; w = stage[2];
        ex    = condHolds(e.cond, mFlags);
        regWM = m.regW && execd[1];
        pcsM  = m.pcs && execd[1];
        regWW = w.regW && execd[2];
        pcsW  = w.pcs && execd[2];
        o = '0;
        o.aluCtlE      = e.aluCtl;
        o.aluSrcE      = e.aluSrc;
        o.branchTakenE = e.branch && ex;
        o.memWriteM    = m.memW && execd[1];
        o.regWriteW    = regWW;
        o.memtoRegW    = w.memtoReg;
        o.pcSrcW       = pcsW;
        o.wa3W         = w.wa3;
`ifdef PIPE_FWD_EN
        o.fwdA = (regWM && e.ra1 == m.wa3) ? 2'b10 : (regWW && e.ra1 == w.wa3) ? 2'b01 : 2'b00;
        o.fwdB = (regWM && e.ra2 == m.wa3) ? 2'b10 : (regWW && e.ra2 == w.wa3) ? 2'b01 : 2'b00;
        hz = e.memtoReg && e.regW && (dWord.ra1 == e.wa3 || dWord.ra2 == e.wa3);
`else
        hz = (e.regW && (dWord.ra1 == e.wa3 || dWord.ra2 == e.wa3)) ||
             (regWM && (dWord.ra1 == m.wa3 || dWord.ra2 == m.wa3));
`endif
        pend     = dWord.pcs || e.pcs || pcsM;
        o.stallD = hz;
        o.stallF = hz || pend;
        o.flushE = hz || o.branchTakenE;
        o.flushD = pend || pcsW || o.branchTakenE;
        o.flags  = mFlags;
        return o;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            stage[i] = '0;
            execd[i] = 1'b0;
        end
        mFlags = 4'b0000;
    endtask

    // Called at each rising edge, before new stimulus is applied.
    task automatic modelAdvance();
        outs_t o;
        logic  ex;
        o  = modelOutputs();
        ex = condHolds(stage[0].cond, mFlags);
        if (stage[0].flagW[1] && ex) mFlags[3:2] = aluF[3:2];
        if (stage[0].flagW[0] && ex) mFlags[1:0] = aluF[1:0];
        stage[2] = stage[1]; execd[2] = execd[1];
        stage[1] = stage[0]; execd[1] = ex;
        stage[0] = o.flushE ? word_t'('0) : dWord;
    endtask

    task automatic applyStimulus(input word_t w, input logic [3:0] f);
        dWord = w;
        aluF  = f;
        bus.PCSD = w.pcs; bus.RegWD = w.regW; bus.MemtoRegD = w.memtoReg;
        bus.MemWD = w.memW; bus.BranchD = w.branch; bus.ALUSrcD = w.aluSrc;
        bus.ALUControlD = w.aluCtl; bus.FlagWD = w.flagW; bus.CondD = w.cond;
        bus.RA1D = w.ra1; bus.RA2D = w.ra2; bus.WA3D = w.wa3;
        bus.ALUFlagsE = f;
    endtask

    function automatic outs_t sampleDut();
        outs_t o;
        o.aluCtlE = bus.ALUControlE; o.aluSrcE = bus.ALUSrcE;
        o.branchTakenE = bus.BranchTakenE; o.memWriteM = bus.MemWriteM;
        o.regWriteW = bus.RegWriteW; o.memtoRegW = bus.MemtoRegW;
        o.pcSrcW = bus.PCSrcW; o.wa3W = bus.WA3W;
        o.fwdA = bus.ForwardAE; o.fwdB = bus.ForwardBE;
        o.stallF = bus.StallF; o.stallD = bus.StallD;
        o.flushD = bus.FlushD; o.flushE = bus.FlushE; o.flags = bus.FlagsQ;
        return o;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareOuts(input string tag, input outs_t a, input outs_t e);
        chk({tag, ".ALUControlE"},  8'(a.aluCtlE),      8'(e.aluCtlE));
        chk({tag, ".ALUSrcE"},      8'(a.aluSrcE),      8'(e.aluSrcE));
        chk({tag, ".BranchTakenE"}, 8'(a.branchTakenE), 8'(e.branchTakenE));
        chk({tag, ".MemWriteM"},    8'(a.memWriteM),    8'(e.memWriteM));
        chk({tag, ".RegWriteW"},    8'(a.regWriteW),    8'(e.regWriteW));
        chk({tag, ".MemtoRegW"},    8'(a.memtoRegW),    8'(e.memtoRegW));
        chk({tag, ".PCSrcW"},       8'(a.pcSrcW),       8'(e.pcSrcW));
        chk({tag, ".WA3W"},         8'(a.wa3W),         8'(e.wa3W));
        chk({tag, ".ForwardAE"},    8'(a.fwdA),         8'(e.fwdA));
        chk({tag, ".ForwardBE"},    8'(a.fwdB),         8'(e.fwdB));
        chk({tag, ".StallF"},       8'(a.stallF),       8'(e.stallF));
        chk({tag, ".StallD"},       8'(a.stallD),       8'(e.stallD));
        chk({tag, ".FlushD"},       8'(a.flushD),       8'(e.flushD));
        chk({tag, ".FlushE"},       8'(a.flushE),       8'(e.flushE));
        chk({tag, ".FlagsQ"},       8'(a.flags),        8'(e.flags));
    endtask

    task automatic checkOutput();
        compareOuts("cycle", sampleDut(), modelOutputs());
    endtask

    always @(negedge clk) begin
        if (checkEnable) checkOutput();
    end

    // One clock: model steps on the edge, new D word arrives just after it,
    // and control returns at the following falling edge.
    task automatic cycle(input word_t w, input logic [3:0] f);
        @(posedge clk);
        modelAdvance();
        #1;
        applyStimulus(w, f);
        @(negedge clk);
    endtask

    // Present a word in D and hold it there while D is stalled.
    task automatic issue(input word_t w, input logic [3:0] f, output int stalls);
        stalls = 0;
        cycle(w, f);
        while (bus.StallD === 1'b1) begin
            stalls++;
            if (stalls > 8) begin
                checkCount++;
                errCount++;
                $display("[TB] FAIL stallBound: StallD still 1 after %0d cycles, expected release", stalls);
                break;
            end
            cycle(w, f);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        word_t nop, add1, sub1, ldr, add5, cmpS, bne, beq, addne, pcw, str;
        int    st;

        nop   = mkWord(0, 0, 0, 0, 0, 2'b00, AL,      4'd0, 4'd0, 4'd0);
        add1  = mkWord(0, 1, 0, 0, 0, 2'b00, AL,      4'd2, 4'd3, 4'd1);
        sub1  = mkWord(0, 1, 0, 0, 0, 2'b00, AL,      4'd1, 4'd3, 4'd2);
        ldr   = mkWord(0, 1, 1, 0, 0, 2'b00, AL,      4'd9, 4'd0, 4'd4);
        add5  = mkWord(0, 1, 0, 0, 0, 2'b00, AL,      4'd4, 4'd4, 4'd5);
        cmpS  = mkWord(0, 0, 0, 0, 0, 2'b11, AL,      4'd1, 4'd2, 4'd0);
        bne   = mkWord(0, 0, 0, 0, 1, 2'b00, 4'b0001, 4'd0, 4'd0, 4'd0);
        beq   = mkWord(0, 0, 0, 0, 1, 2'b00, 4'b0000, 4'd0, 4'd0, 4'd0);
        addne = mkWord(0, 1, 0, 0, 0, 2'b11, 4'b0001, 4'd7, 4'd8, 4'd6);
        pcw   = mkWord(1, 1, 0, 0, 0, 2'b00, AL,      4'd0, 4'd0, 4'd15);
        str   = mkWord(0, 0, 0, 1, 0, 2'b00, AL,      4'd1, 4'd2, 4'd0);

        rst_n = 1'b0;
        applyStimulus(nop, 4'b0000);
        modelReset();
        #12;
        compareOuts("reset", sampleDut(), outs_t'('0));
        @(negedge clk);
        rst_n = 1'b1;
        checkEnable = 1'b1;

        // Dependent ALU pair, then the same pair one instruction apart.
        issue(add1, 4'b0000, st);
        issue(sub1, 4'b0000, st);
        chk("addSub.stalls", 8'(st), 8'(ADD_SUB_STALLS));
        cycle(nop, 4'b0000);
        chk("addSub.ForwardAE", 8'(bus.ForwardAE), 8'(ADD_SUB_FWD));
`ifdef PIPE_FWD_EN
        issue(add1, 4'b0000, st);
        issue(nop, 4'b0000, st);
        issue(sub1, 4'b0000, st);
        cycle(nop, 4'b0000);
        chk("addNopSub.ForwardAE", 8'(bus.ForwardAE), 8'h1);
`endif

        // Load-use
        issue(ldr, 4'b0000, st);
        issue(add5, 4'b0000, st);
        chk("ldrUse.stalls", 8'(st), 8'(LDR_STALLS));
        cycle(nop, 4'b0000);
        chk("ldrUse.ForwardAE", 8'(bus.ForwardAE), 8'(LDR_FWD));
        chk("ldrUse.ForwardBE", 8'(bus.ForwardBE), 8'(LDR_FWD));

        // CMPS sets Z, BNE falls through, BEQ is taken.
        issue(cmpS, 4'b0100, st);
        issue(bne, 4'b0100, st);
        issue(beq, 4'b0100, st);
        chk("bne.BranchTakenE", 8'(bus.BranchTakenE), 8'h0);
        cycle(nop, 4'b0100);
        chk("beq.BranchTakenE", 8'(bus.BranchTakenE), 8'h1);
        chk("beq.FlushD", 8'(bus.FlushD), 8'h1);
        chk("beq.FlushE", 8'(bus.FlushE), 8'h1);
        chk("beq.FlagsQ", 8'(bus.FlagsQ), 8'h4);
        cycle(nop, 4'b0100);
        chk("beqAfter.FlushE", 8'(bus.FlushE), 8'h0);
        chk("beqAfter.FlushD", 8'(bus.FlushD), 8'h0);

        // ADDSNE with Z set must neither write nor touch the flags.
        issue(addne, 4'b1111, st);
        for (int i = 0; i < 3; i++) cycle(nop, 4'b1111);
        chk("addne.RegWriteW", 8'(bus.RegWriteW), 8'h0);
        chk("addne.WA3W", 8'(bus.WA3W), 8'h6);
        chk("addne.FlagsQ", 8'(bus.FlagsQ), 8'h4);

        // Write to R15
        issue(pcw, 4'b0000, st);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pcw%0d.StallF", i), 8'(bus.StallF), 8'h1);
            chk($sformatf("pcw%0d.FlushD", i), 8'(bus.FlushD), 8'h1);
            chk($sformatf("pcw%0d.PCSrcW", i), 8'(bus.PCSrcW), 8'h0);
            cycle(nop, 4'b0000);
        end
        chk("pcw3.PCSrcW", 8'(bus.PCSrcW), 8'h1);
        chk("pcw3.FlushD", 8'(bus.FlushD), 8'h1);
        chk("pcw3.StallF", 8'(bus.StallF), 8'h0);

        // Random traffic, checked every cycle by the compare process.
        for (int i = 0; i < 400; i++) cycle(randWord(), 4'($urandom));

        // Reset while a store sits in E.
        for (int i = 0; i < 3; i++) cycle(nop, 4'b0000);
        issue(str, 4'b0000, st);
        cycle(nop, 4'b0000);
        checkEnable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        compareOuts("midReset", sampleDut(), outs_t'('0));
        @(posedge clk);
        #1;
        chk("midReset.MemWriteMAfterEdge", 8'(bus.MemWriteM), 8'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        checkEnable = 1'b1;
        for (int i = 0; i < 40; i++) cycle(randWord(), 4'($urandom));

        checkEnable = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
